// File: rtl/multicycle_ctrl_hs_if.sv
// Control/handshake bundle between the multicycle control FSM and the datapath.
// master = control FSM side, slave = datapath/memory side.
interface multicycle_ctrl_hs_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Op;
    logic             zero;
    logic             imem_ack;
    logic             dmem_ack;
    logic             resume;

    logic             PCWre;
    logic             ALUSrcA;
    logic             ALUSrcB;
    logic             ALUM2Reg;
    logic             RegWre;
    logic             WrRegData;
    logic             InsMemRW;
    logic             RD;
    logic             WR;
    logic             IRWre;
    logic             ExtSel;
    logic [1:0]       PCSrc;
    logic [1:0]       RegDst;
    logic [2:0]       ALUOp;
    logic             illegal;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] retired;

    modport master (
        input  Op, zero, imem_ack, dmem_ack, resume,
        output PCWre, ALUSrcA, ALUSrcB, ALUM2Reg, RegWre, WrRegData, InsMemRW,
               RD, WR, IRWre, ExtSel, PCSrc, RegDst, ALUOp, illegal, state_o, retired
    );

    modport slave (
        output Op, zero, imem_ack, dmem_ack, resume,
        input  PCWre, ALUSrcA, ALUSrcB, ALUM2Reg, RegWre, WrRegData, InsMemRW,
               RD, WR, IRWre, ExtSel, PCSrc, RegDst, ALUOp, illegal, state_o, retired
    );
endinterface

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle CPU control FSM with imem/dmem valid-ack waits, resumable HALT,
// illegal-opcode detection and a retired-instruction counter.
module multicycle_ctrl_hs #(
    parameter bit IMEM_HS = 1'b1,
    parameter bit DMEM_HS = 1'b1,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                CURST,
    multicycle_ctrl_hs_if.master bus
);

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_R  = 4'b0010,
        S_EXE_B  = 4'b0011,
        S_EXE_M  = 4'b0100,
        S_MEM    = 4'b0101,
        S_WB_R   = 4'b0110,
        S_WB_L   = 4'b0111,
        S_HALTED = 4'b1000
    } state_t;

    localparam logic [5:0] OP_ADDU  = 6'b000000;
    localparam logic [5:0] OP_SUBU  = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b010000;
    localparam logic [5:0] OP_AND   = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTU  = 6'b100110;
    localparam logic [5:0] OP_SLTIU = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_ADDU, OP_SUBU, OP_ADDIU, OP_OR, OP_AND, OP_ORI, OP_SLL,
            OP_SLTU, OP_SLTIU, OP_SW, OP_LW, OP_BEQ, OP_BNE,
            OP_J, OP_JR, OP_JAL, OP_HALT: is_legal = 1'b1;
            default:                      is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_decode(input logic [5:0] op);
        case (op)
            OP_SUBU, OP_BEQ, OP_BNE: alu_decode = 3'b001;
            OP_OR, OP_ORI:           alu_decode = 3'b101;
            OP_AND:                  alu_decode = 3'b110;
            OP_SLTU, OP_SLTIU:       alu_decode = 3'b010;
            OP_SLL:                  alu_decode = 3'b100;
            default:                 alu_decode = 3'b000;
        endcase
    endfunction

    function automatic logic is_imm(input logic [5:0] op);
        is_imm = (op == OP_ADDIU) || (op == OP_ORI) || (op == OP_SLTIU);
    endfunction

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] retired_q;

    logic       imem_ok;
    logic       dmem_ok;
    logic       br_taken;

    logic       pc_wre;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       alu_m2reg;
    logic       reg_wre;
    logic       wr_reg_data;
    logic       ins_mem_rw;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wre;
    logic       ext_sel;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [2:0] alu_op;
    logic       illegal_op;

    // With a handshake disabled the corresponding ack is treated as always present.
    assign imem_ok  = IMEM_HS ? bus.imem_ack : 1'b1;
    assign dmem_ok  = DMEM_HS ? bus.dmem_ack : 1'b1;
    assign br_taken = ((bus.Op == OP_BEQ) &&  bus.zero) ||
                      ((bus.Op == OP_BNE) && !bus.zero);

    always_comb begin
        state_nxt   = state;
        pc_wre      = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 1'b0;
        alu_m2reg   = 1'b0;
        reg_wre     = 1'b0;
        wr_reg_data = 1'b0;
        ins_mem_rw  = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        ir_wre      = 1'b0;
        ext_sel     = 1'b1;
        pc_src      = 2'b00;
        reg_dst     = 2'b10;
        alu_op      = alu_decode(bus.Op);
        illegal_op  = 1'b0;

        case (state)
            S_IF: begin
                ins_mem_rw = 1'b1;
                ir_wre     = imem_ok;
                if (imem_ok) state_nxt = S_ID;
            end

            S_ID: begin
                if (!is_legal(bus.Op)) begin
                    // Undefined opcode: flag it and step over the instruction.
                    illegal_op = 1'b1;
                    pc_wre     = 1'b1;
                    state_nxt  = S_IF;
                end else begin
                    case (bus.Op)
                        OP_J: begin
                            pc_src    = 2'b11;
                            pc_wre    = 1'b1;
                            state_nxt = S_IF;
                        end
                        OP_JAL: begin
                            pc_src      = 2'b11;
                            pc_wre      = 1'b1;
                            reg_wre     = 1'b1;
                            reg_dst     = 2'b00;
                            wr_reg_data = 1'b0;
                            state_nxt   = S_IF;
                        end
                        OP_JR: begin
                            pc_src    = 2'b10;
                            pc_wre    = 1'b1;
                            state_nxt = S_IF;
                        end
                        OP_HALT:        state_nxt = S_HALTED;
                        OP_BEQ, OP_BNE: state_nxt = S_EXE_B;
                        OP_SW, OP_LW:   state_nxt = S_EXE_M;
                        default:        state_nxt = S_EXE_R;
                    endcase
                end
            end

            S_EXE_R, S_WB_R: begin
                // WB_R keeps the EXE_R operand selects so the ALU result stays stable.
                alu_src_a = (bus.Op == OP_SLL);
                alu_src_b = is_imm(bus.Op);
                ext_sel   = (bus.Op != OP_ORI);
                if (state == S_WB_R) begin
                    reg_wre     = 1'b1;
                    wr_reg_data = 1'b1;
                    reg_dst     = is_imm(bus.Op) ? 2'b01 : 2'b10;
                    pc_wre      = 1'b1;
                    state_nxt   = S_IF;
                end else begin
                    state_nxt = S_WB_R;
                end
            end

            S_EXE_B: begin
                pc_src    = br_taken ? 2'b01 : 2'b00;
                pc_wre    = 1'b1;
                state_nxt = S_IF;
            end

            S_EXE_M: begin
                alu_src_b = 1'b1;
                state_nxt = S_MEM;
            end

            S_MEM: begin
                alu_src_b = 1'b1;
                mem_rd    = (bus.Op == OP_LW);
                mem_wr    = (bus.Op == OP_SW);
                if (dmem_ok) begin
                    if (bus.Op == OP_SW) begin
                        pc_wre    = 1'b1;
                        state_nxt = S_IF;
                    end else begin
                        state_nxt = S_WB_L;
                    end
                end
            end

            S_WB_L: begin
                reg_wre     = 1'b1;
                wr_reg_data = 1'b1;
                alu_m2reg   = 1'b1;
                reg_dst     = 2'b01;
                pc_wre      = 1'b1;
                state_nxt   = S_IF;
            end

            S_HALTED: begin
                ext_sel = 1'b0;
                reg_dst = 2'b00;
                alu_op  = 3'b000;
                pc_wre  = bus.resume;
                if (bus.resume) state_nxt = S_IF;
            end

            default: state_nxt = S_IF;
        endcase

        // Reset overrides every control, including the non-zero defaults.
        if (!CURST) begin
            pc_wre      = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 1'b0;
            alu_m2reg   = 1'b0;
            reg_wre     = 1'b0;
            wr_reg_data = 1'b0;
            ins_mem_rw  = 1'b0;
            mem_rd      = 1'b0;
            mem_wr      = 1'b0;
            ir_wre      = 1'b0;
            ext_sel     = 1'b0;
            pc_src      = 2'b00;
            reg_dst     = 2'b00;
            alu_op      = 3'b000;
            illegal_op  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge CURST) begin
        if (!CURST) begin
            state     <= S_IF;
            retired_q <= '0;
        end else begin
            state <= state_nxt;
            if (pc_wre) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.PCWre     = pc_wre;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUM2Reg  = alu_m2reg;
    assign bus.RegWre    = reg_wre;
    assign bus.WrRegData = wr_reg_data;
    assign bus.InsMemRW  = ins_mem_rw;
    assign bus.RD        = mem_rd;
    assign bus.WR        = mem_wr;
    assign bus.IRWre     = ir_wre;
    assign bus.ExtSel    = ext_sel;
    assign bus.PCSrc     = pc_src;
    assign bus.RegDst    = reg_dst;
    assign bus.ALUOp     = alu_op;
    assign bus.illegal   = illegal_op;
    assign bus.state_o   = state;
    assign bus.retired   = retired_q;

endmodule
